// File: rtl/tank_sprite_reader.sv
// Tank sprite reader: latches the tank position and facing once per frame,
// maps the current draw pixel to an address in a left-facing sprite image,
// and returns the palette index three clock edges later. Throughput is one
// pixel per clock.
module tank_sprite_reader #(
    parameter int         SPR_SIZE   = 50,
    parameter logic [3:0] TRANSP_IDX = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  TankX_in,
    input  logic [9:0]  TankY_in,
    input  logic [1:0]  Dir_in,
    output logic [18:0] read_address,
    input  logic [3:0]  ram_data,
    output logic [3:0]  pixel_idx,
    output logic        pixel_on
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam logic [10:0] SIZE11 = 11'(SPR_SIZE);
    localparam logic [18:0] SIZE19 = 19'(SPR_SIZE);
    localparam logic [9:0]  EDGE   = 10'(SPR_SIZE - 1);

    // Shadow copies of the tank state, stable for a whole frame.
    logic [9:0]  r_tx;
    logic [9:0]  r_ty;
    dir_t        r_dir;

    // Pipeline state.
    logic        r_hit_s1;
    logic        r_hit_s2;

    // Combinational hit test and address generation.
    logic        w_hit;
    logic [9:0]  w_ox;
    logic [9:0]  w_oy;
    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic [18:0] w_addr;

    // Shadow registers load only on frame_start; reset wins over frame_start.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments on every flop so all registers see
        // the pre-edge values of each other regardless of statement order.
        if (Reset) begin
            r_tx  <= '0;
            r_ty  <= '0;
            r_dir <= DIR_LEFT;
        end else if (frame_start) begin
            r_tx  <= TankX_in;
            r_ty  <= TankY_in;
            r_dir <= dir_t'(Dir_in);
        end
    end

    // Hit test in 11 bits so the sprite clips at the screen edge instead of
    // wrapping, then rotate the offsets into the left-facing source image.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        w_hit  = 1'b0;
        w_sx   = '0;
        w_sy   = '0;
        w_ox   = DrawX - r_tx;
        w_oy   = DrawY - r_ty;

        w_hit = ({1'b0, DrawX} >= {1'b0, r_tx}) &&
                ({1'b0, DrawX} <  ({1'b0, r_tx} + SIZE11)) &&
                ({1'b0, DrawY} >= {1'b0, r_ty}) &&
                ({1'b0, DrawY} <  ({1'b0, r_ty} + SIZE11));

        case (r_dir)
            DIR_LEFT: begin
                w_sx = w_ox;
                w_sy = w_oy;
            end
            DIR_RIGHT: begin
                w_sx = EDGE - w_ox;
                w_sy = w_oy;
            end
            DIR_UP: begin
                w_sx = w_oy;
                w_sy = EDGE - w_ox;
            end
            DIR_DOWN: begin
                w_sx = EDGE - w_oy;
                w_sy = w_ox;
            end
            default: begin
                w_sx = w_ox;
                w_sy = w_oy;
            end
        endcase

        w_addr = ({9'd0, w_sy} * SIZE19) + {9'd0, w_sx};
    end

    // Stage 1: issue the RAM address; misses park the address at 0 so an
    // out-of-range offset can never reach the RAM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address <= '0;
            r_hit_s1     <= 1'b0;
        end else begin
            read_address <= w_hit ? w_addr : 19'd0;
            r_hit_s1     <= w_hit;
        end
    end

    // Stage 2: carry the hit flag alongside the RAM access latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hit_s2 <= 1'b0;
        end else begin
            r_hit_s2 <= r_hit_s1;
        end
    end

    // Stage 3: register the palette index and the visibility flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_idx <= TRANSP_IDX;
            pixel_on  <= 1'b0;
        end else begin
            pixel_idx <= r_hit_s2 ? ram_data : TRANSP_IDX;
            pixel_on  <= r_hit_s2 && (ram_data != TRANSP_IDX);
        end
    end

endmodule
